// File: rtl/rv_prefetch_buffer_if.sv
// rtl/rv_prefetch_buffer_if.sv - bus bundle between fetch memory port, control unit, decode and the prefetch buffer
//
// Purpose: groups every non-clock/reset signal of rv_prefetch_buffer.
//   slave  modport: the prefetch buffer side (takes *_i, drives *_o)
//   master modport: the surrounding core / memory side
// Signals:
//   boot_addr_i     first fetch address after reset
//   cu_force_i      redirect request, cu_force_pc_i is its word-aligned target
//   d_ready_i       decode accepts the head entry
//   instr_rvalid_i  in-order response valid, instr_rdata_i is the word
//   instr_req_o     request issued (always accepted), instr_addr_o its address
//   f_valid_o       head entry valid, with f_instr_o / f_current_pc_o / f_next_pc_o
interface rv_prefetch_buffer_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] boot_addr_i;
  logic            cu_force_i;
  logic [XLEN-1:0] cu_force_pc_i;
  logic            d_ready_i;
  logic            instr_rvalid_i;
  logic [XLEN-1:0] instr_rdata_i;
  logic            instr_req_o;
  logic [XLEN-1:0] instr_addr_o;
  logic            f_valid_o;
  logic [XLEN-1:0] f_instr_o;
  logic [XLEN-1:0] f_current_pc_o;
  logic [XLEN-1:0] f_next_pc_o;

  modport slave (
    input  boot_addr_i, cu_force_i, cu_force_pc_i, d_ready_i, instr_rvalid_i, instr_rdata_i,
    output instr_req_o, instr_addr_o, f_valid_o, f_instr_o, f_current_pc_o, f_next_pc_o
  );

  modport master (
    output boot_addr_i, cu_force_i, cu_force_pc_i, d_ready_i, instr_rvalid_i, instr_rdata_i,
    input  instr_req_o, instr_addr_o, f_valid_o, f_instr_o, f_current_pc_o, f_next_pc_o
  );
endinterface

// File: rtl/rv_prefetch_buffer.sv
// rtl/rv_prefetch_buffer.sv - in-order instruction prefetch buffer with redirect flush
//
// Purpose: keeps up to MAX_OUTSTANDING instruction requests in flight and queues the
// returned words, tagged with their PC, in a DEPTH-entry FIFO feeding decode. A redirect
// empties the FIFO and discards responses still owed to the old stream.
// Ports:
//   clk_i   clock, all state on the rising edge
//   rst_i   synchronous active-high reset
//   bus     rv_prefetch_buffer_if.slave (memory request/response, redirect, decode head)
// Option: RV_PREFETCH_BYPASS_EN - when defined, an accepted response arriving at an empty
// FIFO is presented to decode in the same cycle (and not stored if decode takes it).
module rv_prefetch_buffer #(
  parameter int XLEN            = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rv_prefetch_buffer_if.slave bus
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [OW-1:0]   MAX_C   = OW'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] ret_pc_q, ret_pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   disc_q, disc_d;
  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [DEPTH];

  logic            fifo_empty;
  logic            resp_ok;
  logic            accept;
  logic            issue;
  logic            byp_hit;
  logic            head_valid;
  logic            fifo_pop;
  logic            push;
  logic [XLEN-1:0] head_instr;
  logic [XLEN-1:0] head_pc;
  logic [CW:0]     occupancy;

  always_comb begin
    fifo_empty = (count_q == '0);
    // A response with nothing outstanding is an orphan and is ignored.
    resp_ok    = !rst_i && bus.instr_rvalid_i && (outst_q != '0);
    accept     = resp_ok && !bus.cu_force_i && (disc_q == '0);
    // Slots already promised: stored words plus live (non-discarded) requests.
    occupancy  = (CW + 1)'(count_q) + (CW + 1)'(outst_q - disc_q);
    issue      = !rst_i && !bus.cu_force_i && (outst_q < MAX_C) && (occupancy < DEPTH_C);

`ifdef RV_PREFETCH_BYPASS_EN
    byp_hit = accept && fifo_empty;
`else
    byp_hit = 1'b0;
`endif

    head_valid = !fifo_empty || byp_hit;
    if (!fifo_empty) begin
      head_instr = fifo_instr_q[rd_ptr_q];
      head_pc    = fifo_pc_q[rd_ptr_q];
    end else if (byp_hit) begin
      head_instr = bus.instr_rdata_i;
      head_pc    = ret_pc_q;
    end else begin
      head_instr = '0;
      head_pc    = ret_pc_q;
    end

    fifo_pop = head_valid && bus.d_ready_i && !bus.cu_force_i && !fifo_empty;
    // A bypassed word that decode takes immediately never needs a FIFO slot.
    push     = accept && !(byp_hit && bus.d_ready_i);

    fetch_pc_d = fetch_pc_q;
    ret_pc_d   = ret_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    outst_d    = outst_q + OW'(issue) - OW'(resp_ok);
    disc_d     = disc_q;

    if (bus.cu_force_i) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc_d = bus.cu_force_pc_i;
      ret_pc_d   = bus.cu_force_pc_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      disc_d     = outst_d;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (resp_ok && (disc_q != '0)) disc_d = disc_q - OW'(1);
      if (accept) ret_pc_d = ret_pc_q + PC_STEP;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(fifo_pop);
    end

    bus.instr_req_o    = issue;
    bus.instr_addr_o   = fetch_pc_q;
    bus.f_valid_o      = head_valid;
    bus.f_instr_o      = head_instr;
    bus.f_current_pc_o = head_pc;
    bus.f_next_pc_o    = head_pc + PC_STEP;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= bus.boot_addr_i;
      ret_pc_q   <= bus.boot_addr_i;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.instr_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= ret_pc_q;
    end
  end

  a_no_orphan_response: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.instr_rvalid_i && (outst_q == '0)));

endmodule

// File: tb/tb_rv_prefetch_buffer.sv
// tb/tb_rv_prefetch_buffer.sv - self-checking bench for rv_prefetch_buffer
module tb_rv_prefetch_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
`ifdef RV_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  // cycles from the response cycle's request to head-valid, counted from the request at L=1
  localparam int VLAT = BYP ? 1 : 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat = 1;

  rv_prefetch_buffer_if #(.XLEN(XLEN)) bus ();

  rv_prefetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_t;
  mem_t        mq[$];
  logic [31:0] del_pc[$];
  int          del_cyc[$];

  // model state
  bit          m_init = 1'b0;
  logic [31:0] m_fetch, m_ret;
  logic [31:0] fq[$];
  int          live = 0;
  int          stale = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_del(input string name, input int idx, input logic [31:0] exp_pc, input int exp_cyc);
    checks++;
    if (idx >= del_pc.size()) begin
      failures++;
      $display("FAIL %s: delivery %0d missing, expected pc 0x%08h", name, idx, exp_pc);
    end else if (del_pc[idx] !== exp_pc || (exp_cyc >= 0 && del_cyc[idx] != exp_cyc)) begin
      failures++;
      $display("FAIL %s: got pc 0x%08h at cyc %0d expected pc 0x%08h at cyc %0d",
               name, del_pc[idx], del_cyc[idx], exp_pc, exp_cyc);
    end
  endtask

  // memory response driver: fixed latency, in order
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.instr_rvalid_i = 1'b1;
      bus.instr_rdata_i  = mq[0].data;
      void'(mq.pop_front());
    end else begin
      bus.instr_rvalid_i = 1'b0;
      bus.instr_rdata_i  = '0;
    end
  end

  // memory request capture, delivery log, model compare and model update
  initial begin
    logic [31:0] e_pc;
    logic        e_req, e_valid, resp, acc, byp, was_empty;
    forever begin
      @(negedge clk);
      if (rst) mq.delete();
      else if (bus.instr_req_o) mq.push_back('{cyc + lat, mem_word(bus.instr_addr_o)});
      if (!rst && bus.f_valid_o && bus.d_ready_i && !bus.cu_force_i) begin
        del_pc.push_back(bus.f_current_pc_o);
        del_cyc.push_back(cyc);
      end

      e_req   = !rst && !bus.cu_force_i && (live + stale) < MAXO && (fq.size() + live) < DEPTH;
      resp    = !rst && bus.instr_rvalid_i && (live + stale) > 0;
      acc     = resp && stale == 0 && !bus.cu_force_i;
      byp     = BYP && acc && fq.size() == 0;
      e_valid = fq.size() > 0 || byp;
      e_pc    = (fq.size() > 0) ? fq[0] : m_ret;

      if (m_init) begin
        chk1("m_req", bus.instr_req_o, e_req);
        chk("m_addr", bus.instr_addr_o, m_fetch);
        chk1("m_valid", bus.f_valid_o, e_valid);
        if (e_valid) begin
          chk("m_pc", bus.f_current_pc_o, e_pc);
          chk("m_instr", bus.f_instr_o, mem_word(e_pc));
          chk("m_next_pc", bus.f_next_pc_o, e_pc + 32'd4);
        end
      end

      if (rst) begin
        m_fetch = bus.boot_addr_i;
        m_ret   = bus.boot_addr_i;
        fq.delete();
        live    = 0;
        stale   = 0;
        m_init  = 1'b1;
      end else if (bus.cu_force_i) begin
        if (resp) begin
          if (stale > 0) stale--;
          else live--;
        end
        stale   = stale + live;
        live    = 0;
        fq.delete();
        m_fetch = bus.cu_force_pc_i;
        m_ret   = bus.cu_force_pc_i;
      end else begin
        was_empty = (fq.size() == 0);
        if (e_valid && bus.d_ready_i && !was_empty) void'(fq.pop_front());
        if (resp) begin
          if (stale > 0) stale--;
          else begin
            live--;
            if (!(BYP && was_empty && bus.d_ready_i)) fq.push_back(m_ret);
            m_ret = m_ret + 32'd4;
          end
        end
        if (e_req) begin
          m_fetch = m_fetch + 32'd4;
          live++;
        end
      end
    end
  end

  task automatic do_reset(input logic [31:0] boot, input int l);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.boot_addr_i = boot;
    bus.cu_force_i  = 1'b0;
    @(posedge clk); #1;
    lat = l;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int r;
    rst               = 1'b1;
    bus.boot_addr_i   = 32'h1000;
    bus.cu_force_i    = 1'b0;
    bus.cu_force_pc_i = '0;
    bus.d_ready_i     = 1'b1;
    lat               = 1;

    // reset values
    repeat (2) @(negedge clk);
    chk1("rst_req", bus.instr_req_o, 1'b0);
    chk("rst_addr", bus.instr_addr_o, 32'h1000);
    chk1("rst_valid", bus.f_valid_o, 1'b0);
    chk("rst_instr", bus.f_instr_o, 32'h0);
    chk("rst_cur_pc", bus.f_current_pc_o, 32'h1000);
    chk("rst_next_pc", bus.f_next_pc_o, 32'h1004);

    // streaming at L=1
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 3) begin
        chk1("t1_req", bus.instr_req_o, 1'b1);
        chk("t1_addr", bus.instr_addr_o, 32'h1000 + 4 * k);
      end
      if (k == VLAT - 1) chk1("t1_valid_early", bus.f_valid_o, 1'b0);
      if (k == VLAT) begin
        chk1("t1_valid_first", bus.f_valid_o, 1'b1);
        chk("t1_pc_first", bus.f_current_pc_o, 32'h1000);
      end
      if (k == VLAT + 1) chk("t1_pc_second", bus.f_current_pc_o, 32'h1004);
    end

    // decode stalled: FIFO fills to DEPTH, then drains in order
    do_reset(32'h1000, 1);
    bus.d_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk1("t2_req_last", bus.instr_req_o, 1'b1);
        chk("t2_addr_last", bus.instr_addr_o, 32'h100C);
      end
      if (k == 4 || k == 9) chk1("t2_req_full", bus.instr_req_o, 1'b0);
      if (k == 9) begin
        chk1("t2_valid_held", bus.f_valid_o, 1'b1);
        chk("t2_pc_held", bus.f_current_pc_o, 32'h1000);
      end
    end
    @(posedge clk); #1;
    bus.d_ready_i = 1'b1;
    del_pc.delete();
    del_cyc.delete();
    r = cyc;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_del("t2_drain", i, 32'h1000 + 4 * i, r + i);

    // redirect with two old requests in flight at L=3
    do_reset(32'h1000, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.cu_force_i    = 1'b1;
    bus.cu_force_pc_i = 32'h2000;
    del_pc.delete();
    del_cyc.delete();
    @(negedge clk);
    chk1("t3_force_noreq", bus.instr_req_o, 1'b0);
    @(posedge clk); #1;
    bus.cu_force_i = 1'b0;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) chk1("t3_req_blocked", bus.instr_req_o, 1'b0);
      if (k == 4) begin
        chk1("t3_req_new", bus.instr_req_o, 1'b1);
        chk("t3_addr_new", bus.instr_addr_o, 32'h2000);
      end
    end
    chk_del("t3_first", 0, 32'h2000, -1);
    chk_del("t3_second", 1, 32'h2004, -1);

    // redirect colliding with a response while FIFO holds a word
    do_reset(32'h1000, 1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    bus.cu_force_i    = 1'b1;
    bus.cu_force_pc_i = 32'h3000;
    del_pc.delete();
    del_cyc.delete();
    @(negedge clk);
    chk1("t4_head_before", bus.f_valid_o, 1'b1);
    @(posedge clk); #1;
    bus.cu_force_i = 1'b0;
    @(negedge clk);
    chk1("t4_empty_after", bus.f_valid_o, 1'b0);
    repeat (6) @(negedge clk);
    chk_del("t4_first", 0, 32'h3000, -1);

    // address wrap at the top of the space
    @(posedge clk); #1;
    bus.cu_force_i    = 1'b1;
    bus.cu_force_pc_i = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    bus.cu_force_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) chk("t5_addr0", bus.instr_addr_o, 32'hFFFF_FFF8);
      if (k == 2) chk("t5_addr1", bus.instr_addr_o, 32'hFFFF_FFFC);
      if (k == 3) chk("t5_addr2", bus.instr_addr_o, 32'h0000_0000);
      if (k == 2 + VLAT) begin
        chk("t5_head_pc", bus.f_current_pc_o, 32'hFFFF_FFFC);
        chk("t5_next_wrap", bus.f_next_pc_o, 32'h0000_0000);
      end
    end

    // one-cycle reset with two requests outstanding, response lands during reset
    do_reset(32'h1000, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.boot_addr_i = 32'h4000;
    @(negedge clk);
    chk1("t6_rst_noreq", bus.instr_req_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    del_pc.delete();
    del_cyc.delete();
    @(negedge clk);
    chk1("t6_valid", bus.f_valid_o, 1'b0);
    chk("t6_instr", bus.f_instr_o, 32'h0);
    chk("t6_cur_pc", bus.f_current_pc_o, 32'h4000);
    chk("t6_next_pc", bus.f_next_pc_o, 32'h4004);
    chk1("t6_req", bus.instr_req_o, 1'b1);
    chk("t6_addr", bus.instr_addr_o, 32'h4000);
    repeat (8) @(negedge clk);
    chk_del("t6_first", 0, 32'h4000, -1);
    chk_del("t6_second", 1, 32'h4004, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
